// File: rtl/multi_design_select.sv
// multi_design_select
//   Runtime selector that places one of N_DESIGNS user designs on the shared
//   GPIO pads. Every design except the active one is held in reset. On each
//   switch the pads are isolated (outputs low, all inputs) for RESET_CYCLES
//   cycles while every design is in reset. After that window the new design
//   is released and drives the pads.
// Ports:
//   i_clk, i_reset        clock and asynchronous active-high reset
//   i_sel_valid, i_sel_id select request strobe and requested design index
//   o_sel_ready           a request can be accepted (RUN)
//   o_sel_err             one-cycle pulse for an out-of-range request
//   o_active_id           currently selected design
//   o_switching           pads isolated (HOLD)
//   o_design_reset        per-design active-high reset
//   i_design_out/_oeb     per-design pad data; design k uses [k*IO_W +: IO_W]
//   o_io_out/_oeb         pad data to the pads
module multi_design_select #(
  parameter int unsigned N_DESIGNS    = 4,
  parameter int unsigned IO_W         = 38,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned DEFAULT_ID   = 0,
  localparam int unsigned SEL_W = ($clog2(N_DESIGNS) > 1) ? $clog2(N_DESIGNS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_sel_valid,
  input  logic [SEL_W-1:0]          i_sel_id,
  output logic                      o_sel_ready,
  output logic                      o_sel_err,
  output logic [SEL_W-1:0]          o_active_id,
  output logic                      o_switching,
  output logic [N_DESIGNS-1:0]      o_design_reset,
  input  logic [N_DESIGNS*IO_W-1:0] i_design_out,
  input  logic [N_DESIGNS*IO_W-1:0] i_design_oeb,
  output logic [IO_W-1:0]           o_io_out,
  output logic [IO_W-1:0]           o_io_oeb
);

  localparam int unsigned CNT_W =
      ($clog2(RESET_CYCLES + 1) > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RESET_CYCLES - 1);
  localparam logic [SEL_W-1:0] DEF_ID   = SEL_W'(DEFAULT_ID);
  // One bit wider than the select so that N_DESIGNS itself is representable.
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W + 1)'(N_DESIGNS);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]           r_state, w_state_d;
  logic [CNT_W-1:0]     r_cnt, w_cnt_d;
  logic [SEL_W-1:0]     r_active_id, w_active_id_d;
  logic [N_DESIGNS-1:0] r_design_reset, w_design_reset_d;
  logic                 r_switching, r_sel_ready, r_sel_err, w_sel_err_d;

  // Next-state logic. Control outputs are derived from the next state so that
  // their registered copies always agree with r_state.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_active_id_d = r_active_id;
    w_sel_err_d   = 1'b0;
    if (r_state == ST_HOLD) begin
      if (r_cnt == '0) begin
        w_state_d = ST_RUN;
      end else begin
        w_cnt_d = r_cnt - CNT_W'(1);
      end
    end else if (i_sel_valid && r_sel_ready) begin
      if ({1'b0, i_sel_id} >= N_LIM) begin
        w_sel_err_d = 1'b1;
      end else begin
        w_active_id_d = i_sel_id;
        w_cnt_d       = CNT_INIT;
        w_state_d     = ST_HOLD;
      end
    end
  end

  always_comb begin
    w_design_reset_d = '1;
    for (int unsigned k = 0; k < N_DESIGNS; k++) begin
      if (w_state_d == ST_RUN && w_active_id_d == SEL_W'(k)) begin
        w_design_reset_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_HOLD;
      r_cnt          <= CNT_INIT;
      r_active_id    <= DEF_ID;
      r_design_reset <= '1;
      r_switching    <= 1'b1;
      r_sel_ready    <= 1'b0;
      r_sel_err      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_active_id    <= w_active_id_d;
      r_design_reset <= w_design_reset_d;
      r_switching    <= (w_state_d == ST_HOLD);
      r_sel_ready    <= (w_state_d == ST_RUN);
      r_sel_err      <= w_sel_err_d;
    end
  end

  // Pad mux: isolated in HOLD, otherwise the active design's slice.
  always_comb begin
    o_io_out = '0;
    o_io_oeb = '1;
    if (r_state == ST_RUN) begin
      for (int unsigned k = 0; k < N_DESIGNS; k++) begin
        if (r_active_id == SEL_W'(k)) begin
          o_io_out = i_design_out[k*IO_W +: IO_W];
          o_io_oeb = i_design_oeb[k*IO_W +: IO_W];
        end
      end
    end
  end

  assign o_sel_ready    = r_sel_ready;
  assign o_sel_err      = r_sel_err;
  assign o_active_id    = r_active_id;
  assign o_switching    = r_switching;
  assign o_design_reset = r_design_reset;

endmodule
